// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_responder
// Purpose  : Emulates one x16 SDR SDRAM device. It decodes the command pins,
//            tracks the mode register and the open row of each bank, and
//            serves read and write bursts from an internal word store.
//            Store index = low MEM_AW bits of {ba,row,col}.
// Options  : `define SDRAM_RESP_CHECK_EN to count protocol violations on
//            err_cnt. Without it err_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_responder #(
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  input  logic [1:0]        ba,
  input  logic [ROW_W-1:0]  addr,
  input  logic              ldqm,
  input  logic              udqm,
  input  logic [15:0]       dq_in,
  output logic [15:0]       dq_out,
  output logic [1:0]        dq_oe,
  output logic [15:0]       ref_cnt,
  output logic [7:0]        err_cnt
);

  localparam int FULL_W = 2 + ROW_W + COL_W;

  // Command encodings on {cs_n,ras_n,cas_n,we_n}
  localparam logic [3:0] c_cmd_act   = 4'b0011;
  localparam logic [3:0] c_cmd_read  = 4'b0101;
  localparam logic [3:0] c_cmd_write = 4'b0100;
  localparam logic [3:0] c_cmd_pre   = 4'b0010;
  localparam logic [3:0] c_cmd_ref   = 4'b0001;
  localparam logic [3:0] c_cmd_mrs   = 4'b0000;
  localparam logic [3:0] c_cmd_bst   = 4'b0110;

  // Column of beat idx inside a len-aligned block (len is 1, 2, 4 or 8)
  function automatic logic [COL_W-1:0] f_bcol(input logic [COL_W-1:0] col,
                                              input logic [3:0] len,
                                              input logic [3:0] idx);
    logic [COL_W-1:0] m;
    logic [COL_W-1:0] s;
    m = {{(COL_W-4){1'b0}}, len - 4'd1};
    s = col + {{(COL_W-4){1'b0}}, idx};
    return (col & ~m) | (s & m);
  endfunction

  // Command decode
  logic [3:0] w_cmd;
  logic       w_is_act, w_is_read, w_is_write, w_is_pre, w_is_ref, w_is_mrs, w_is_bst;
  assign w_cmd      = {cs_n, ras_n, cas_n, we_n};
  assign w_is_act   = (w_cmd == c_cmd_act);
  assign w_is_read  = (w_cmd == c_cmd_read);
  assign w_is_write = (w_cmd == c_cmd_write);
  assign w_is_pre   = (w_cmd == c_cmd_pre);
  assign w_is_ref   = (w_cmd == c_cmd_ref);
  assign w_is_mrs   = (w_cmd == c_cmd_mrs);
  assign w_is_bst   = (w_cmd == c_cmd_bst);

  // Mode and bank state
  logic [3:0]       r_bl;
  logic             r_cl3;
  logic [3:0]       r_open;
  logic [ROW_W-1:0] r_row [4];

  // Active burst state (beat 0 is issued on the command edge itself)
  logic             r_b_act, r_b_wr, r_b_ap, r_b_cl3;
  logic [1:0]       r_b_ba;
  logic [ROW_W-1:0] r_b_row;
  logic [COL_W-1:0] r_b_col;
  logic [3:0]       r_b_idx, r_b_len;

  // Read pipeline and output registers
  logic              r_p1_v, r_p1_cl3, r_p2_v;
  logic [MEM_AW-1:0] r_p1_idx, r_p2_idx;
  logic [1:0]        r_dqm_d;
  logic [15:0]       r_dq_out;
  logic [1:0]        r_dq_oe;
  logic [15:0]       r_ref_cnt;
  logic [15:0]       r_mem [0:(1<<MEM_AW)-1];

  // A READ/WRITE only acts when its bank is open
  logic w_rw_ok, w_pre_kill, w_cont, w_wr_cancel;
  assign w_rw_ok     = (w_is_read || w_is_write) && r_open[ba];
  assign w_pre_kill  = w_is_pre && (addr[10] || (ba == r_b_ba));
  assign w_cont      = r_b_act && !w_rw_ok && !w_is_bst && !w_pre_kill;
  assign w_wr_cancel = w_rw_ok && w_is_write;

  // Beat issued on this edge: either beat 0 of a new command or the next beat
  logic             w_iss, w_iss_wr, w_iss_last, w_iss_ap, w_iss_cl3;
  logic [1:0]       w_iss_ba;
  logic [ROW_W-1:0] w_iss_row;
  logic [COL_W-1:0] w_iss_col;
  always_comb begin
    w_iss      = 1'b0;
    w_iss_wr   = 1'b0;
    w_iss_last = 1'b0;
    w_iss_ap   = 1'b0;
    w_iss_cl3  = r_cl3;
    w_iss_ba   = ba;
    w_iss_row  = r_row[ba];
    w_iss_col  = addr[COL_W-1:0];
    if (w_rw_ok) begin
      w_iss      = 1'b1;
      w_iss_wr   = w_is_write;
      w_iss_last = (r_bl == 4'd1);
      w_iss_ap   = addr[10];
    end else if (w_cont) begin
      w_iss      = 1'b1;
      w_iss_wr   = r_b_wr;
      w_iss_last = (r_b_idx == (r_b_len - 4'd1));
      w_iss_ap   = r_b_ap;
      w_iss_cl3  = r_b_cl3;
      w_iss_ba   = r_b_ba;
      w_iss_row  = r_b_row;
      w_iss_col  = f_bcol(r_b_col, r_b_len, r_b_idx);
    end
  end

  logic [FULL_W-1:0] w_full;
  logic [MEM_AW-1:0] w_iss_idx;
  logic              w_unused_full;
  assign w_full        = {w_iss_ba, w_iss_row, w_iss_col};
  assign w_iss_idx     = w_full[MEM_AW-1:0];
  assign w_unused_full = ^w_full;

  // Read output source: oldest stage that is due this edge
  logic              w_rd_v;
  logic [MEM_AW-1:0] w_rd_idx;
  always_comb begin
    w_rd_v   = 1'b0;
    w_rd_idx = r_p1_idx;
    if (r_p2_v) begin
      w_rd_v   = 1'b1;
      w_rd_idx = r_p2_idx;
    end else if (r_p1_v && !r_p1_cl3) begin
      w_rd_v   = 1'b1;
      w_rd_idx = r_p1_idx;
    end
  end

  // Mode register: BL from A[2:0], CL from A[6:4]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bl  <= 4'd1;
      r_cl3 <= 1'b0;
    end else if (w_is_mrs) begin
      case (addr[2:0])
        3'b001:  r_bl <= 4'd2;
        3'b010:  r_bl <= 4'd4;
        3'b011:  r_bl <= 4'd8;
        default: r_bl <= 4'd1;
      endcase
      r_cl3 <= (addr[6:4] != 3'b010);
    end
  end

  // Bank open/row tracking, including auto-precharge closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open <= 4'b0000;
      for (int b = 0; b < 4; b++) r_row[b] <= '0;
    end else begin
      if (r_b_act && r_b_ap && (w_rw_ok || w_is_bst)) r_open[r_b_ba] <= 1'b0;
      if (w_iss && w_iss_last && w_iss_ap) r_open[w_iss_ba] <= 1'b0;
      if (w_is_pre) begin
        if (addr[10]) r_open <= 4'b0000;
        else          r_open[ba] <= 1'b0;
      end
      if (w_is_act) begin
        r_open[ba] <= 1'b1;
        r_row[ba]  <= addr;
      end
    end
  end

  // Burst sequencer: start, advance, or terminate the current burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_act <= 1'b0;
      r_b_wr  <= 1'b0;
      r_b_ap  <= 1'b0;
      r_b_cl3 <= 1'b0;
      r_b_ba  <= 2'd0;
      r_b_row <= '0;
      r_b_col <= '0;
      r_b_idx <= 4'd0;
      r_b_len <= 4'd1;
    end else if (w_rw_ok) begin
      r_b_act <= (r_bl != 4'd1);
      r_b_wr  <= w_is_write;
      r_b_ap  <= addr[10];
      r_b_cl3 <= r_cl3;
      r_b_ba  <= ba;
      r_b_row <= r_row[ba];
      r_b_col <= addr[COL_W-1:0];
      r_b_idx <= 4'd1;
      r_b_len <= r_bl;
    end else if (w_cont) begin
      r_b_idx <= r_b_idx + 4'd1;
      if (w_iss_last) r_b_act <= 1'b0;
    end else if (w_is_bst || w_pre_kill) begin
      r_b_act <= 1'b0;
    end
  end

  // Word store with per-byte write enables (contents survive reset)
  always_ff @(posedge clk) begin
    if (w_iss && w_iss_wr) begin
      if (!ldqm) r_mem[w_iss_idx][7:0]  <= dq_in[7:0];
      if (!udqm) r_mem[w_iss_idx][15:8] <= dq_in[15:8];
    end
  end

  // Read pipeline (CL-1 stages) and registered data/enable outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_v   <= 1'b0;
      r_p1_cl3 <= 1'b0;
      r_p1_idx <= '0;
      r_p2_v   <= 1'b0;
      r_p2_idx <= '0;
      r_dqm_d  <= 2'b00;
      r_dq_out <= 16'h0000;
      r_dq_oe  <= 2'b00;
    end else begin
      r_dqm_d <= {udqm, ldqm};
      if (w_wr_cancel) begin
        r_p1_v  <= 1'b0;
        r_p2_v  <= 1'b0;
        r_dq_oe <= 2'b00;
      end else begin
        r_p1_v   <= w_iss && !w_iss_wr;
        r_p1_idx <= w_iss_idx;
        r_p1_cl3 <= w_iss_cl3;
        r_p2_v   <= r_p1_v && r_p1_cl3;
        r_p2_idx <= r_p1_idx;
        if (w_rd_v) begin
          r_dq_out <= r_mem[w_rd_idx];
          r_dq_oe  <= ~r_dqm_d;
        end else begin
          r_dq_oe  <= 2'b00;
        end
      end
    end
  end

  // Refresh counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ref_cnt <= 16'h0000;
    else if (w_is_ref) r_ref_cnt <= r_ref_cnt + 16'd1;
  end

  assign dq_out  = r_dq_out;
  assign dq_oe   = r_dq_oe;
  assign ref_cnt = r_ref_cnt;

`ifdef SDRAM_RESP_CHECK_EN
  logic       w_viol;
  logic [7:0] r_err_cnt;
  assign w_viol = (w_is_act && r_open[ba])
               || ((w_is_read || w_is_write) && !r_open[ba])
               || (w_is_ref && (r_open != 4'b0000))
               || (w_is_mrs && (addr[2] || ((addr[6:4] != 3'b010) && (addr[6:4] != 3'b011))));

  // Saturating violation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_err_cnt <= 8'h00;
    else if (w_viol && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_responder
// Purpose  : Directed scoreboard bench for sdram_responder. Stimulus pushes
//            expected read beats (sample edge, data, enables); a monitor pops
//            them whenever dq_oe is nonzero.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_responder;

  localparam logic [3:0] c_nop = 4'b0111;
  localparam logic [3:0] c_act = 4'b0011;
  localparam logic [3:0] c_rd  = 4'b0101;
  localparam logic [3:0] c_wr  = 4'b0100;
  localparam logic [3:0] c_pre = 4'b0010;
  localparam logic [3:0] c_ref = 4'b0001;
  localparam logic [3:0] c_mrs = 4'b0000;
`ifdef SDRAM_RESP_CHECK_EN
  localparam int c_chk = 1;
`else
  localparam int c_chk = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = 2'd0;
  logic [11:0] addr = 12'd0;
  logic        ldqm = 1'b0, udqm = 1'b0;
  logic [15:0] dq_in = 16'd0;
  logic [15:0] dq_out;
  logic [1:0]  dq_oe;
  logic [15:0] ref_cnt;
  logic [7:0]  err_cnt;

  sdram_responder dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .ldqm(ldqm), .udqm(udqm), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .ref_cnt(ref_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic [1:0]  oe;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  // Monitor: compare every driven beat against the scoreboard head
  always @(negedge clk) begin : mon
    int   s;
    exp_t e;
    s = edge_n + 1;
    while (q.size() > 0 && q[0].cyc < s) begin
      e = q.pop_front();
      n_vec++; n_err++;
      $display("FAIL beat_missing: no beat at edge %0d, required d=%h oe=%b", e.cyc, e.d, e.oe);
    end
    if (dq_oe != 2'b00) begin
      n_vec++;
      if (q.size() == 0 || q[0].cyc != s) begin
        n_err++;
        $display("FAIL beat_unexpected: edge %0d got d=%h oe=%b, none required", s, dq_out, dq_oe);
      end else begin
        e = q.pop_front();
        if (dq_out !== e.d || dq_oe !== e.oe) begin
          n_err++;
          $display("FAIL beat_data: edge %0d got d=%h oe=%b, required d=%h oe=%b",
                   s, dq_out, dq_oe, e.d, e.oe);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                     input logic [15:0] d, input logic um, input logic lm, output int k);
    @(negedge clk);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b; addr = a; dq_in = d; udqm = um; ldqm = lm;
    k = edge_n + 1;
  endtask

  task automatic nop(input int n);
    int k;
    for (int i = 0; i < n; i++) cmd(c_nop, 2'd0, 12'd0, 16'd0, 1'b0, 1'b0, k);
  endtask

  task automatic push(input int cyc, input logic [15:0] d, input logic [1:0] oe);
    exp_t e;
    e.cyc = cyc; e.d = d; e.oe = oe;
    q.push_back(e);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_dq_oe", {30'd0, dq_oe}, 32'd0);
    chk("reset_dq_out", {16'd0, dq_out}, 32'd0);
    chk("reset_ref_cnt", {16'd0, ref_cnt}, 32'd0);
    chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;

    // CL2 BL1 single write/read
    cmd(c_mrs, 2'd0, 12'h020, 16'd0, 1'b0, 1'b0, k);
    cmd(c_act, 2'd1, 12'd5, 16'd0, 1'b0, 1'b0, k);
    cmd(c_wr, 2'd1, 12'd3, 16'hA55A, 1'b0, 1'b0, k);
    cmd(c_rd, 2'd1, 12'd3, 16'd0, 1'b0, 1'b0, k);
    push(k + 2, 16'hA55A, 2'b11);
    nop(4);

    // CL3 BL8 wrap inside the 8-block
    cmd(c_mrs, 2'd0, 12'h033, 16'd0, 1'b0, 1'b0, k);
    cmd(c_act, 2'd0, 12'd7, 16'd0, 1'b0, 1'b0, k);
    cmd(c_wr, 2'd0, 12'd6, 16'd0, 1'b0, 1'b0, k);
    for (int i = 1; i < 8; i++) cmd(c_nop, 2'd0, 12'd0, 16'(i), 1'b0, 1'b0, k);
    cmd(c_rd, 2'd0, 12'd0, 16'd0, 1'b0, 1'b0, k);
    for (int i = 0; i < 8; i++) push(k + 3 + i, 16'((i + 2) % 8), 2'b11);
    nop(12);

    // Byte masks on write and read
    cmd(c_mrs, 2'd0, 12'h020, 16'd0, 1'b0, 1'b0, k);
    cmd(c_wr, 2'd1, 12'd10, 16'h1234, 1'b0, 1'b0, k);
    cmd(c_wr, 2'd1, 12'd10, 16'hFFFF, 1'b1, 1'b0, k);
    cmd(c_rd, 2'd1, 12'd10, 16'd0, 1'b0, 1'b0, k);
    push(k + 2, 16'h12FF, 2'b11);
    nop(2);
    cmd(c_rd, 2'd1, 12'd10, 16'd0, 1'b0, 1'b1, k);
    push(k + 2, 16'h12FF, 2'b10);
    nop(4);

    // Accesses to a closed bank are ignored
    cmd(c_rd, 2'd2, 12'd0, 16'd0, 1'b0, 1'b0, k);
    nop(4);
    chk("err_closed_read", {24'd0, err_cnt}, 32'(c_chk * 1));
    cmd(c_act, 2'd3, 12'd0, 16'd0, 1'b0, 1'b0, k);
    cmd(c_wr, 2'd3, 12'd20, 16'h5555, 1'b0, 1'b0, k);
    cmd(c_wr, 2'd2, 12'd20, 16'hDEAD, 1'b0, 1'b0, k);
    cmd(c_rd, 2'd3, 12'd20, 16'd0, 1'b0, 1'b0, k);
    push(k + 2, 16'h5555, 2'b11);
    nop(4);
    chk("err_closed_write", {24'd0, err_cnt}, 32'(c_chk * 2));

    // Auto-precharge write BL4, then refreshes
    cmd(c_pre, 2'd0, 12'h400, 16'd0, 1'b0, 1'b0, k);
    cmd(c_mrs, 2'd0, 12'h022, 16'd0, 1'b0, 1'b0, k);
    cmd(c_act, 2'd0, 12'd7, 16'd0, 1'b0, 1'b0, k);
    cmd(c_wr, 2'd0, 12'h408, 16'h0100, 1'b0, 1'b0, k);
    for (int i = 1; i < 4; i++) cmd(c_nop, 2'd0, 12'd0, 16'(16'h0100 + i), 1'b0, 1'b0, k);
    cmd(c_rd, 2'd0, 12'd8, 16'd0, 1'b0, 1'b0, k);
    nop(3);
    chk("err_ap_closed", {24'd0, err_cnt}, 32'(c_chk * 3));
    for (int i = 0; i < 3; i++) cmd(c_ref, 2'd0, 12'd0, 16'd0, 1'b0, 1'b0, k);
    nop(1);
    chk("ref_cnt_3", {16'd0, ref_cnt}, 32'd3);
    chk("err_after_ref", {24'd0, err_cnt}, 32'(c_chk * 3));
    cmd(c_act, 2'd0, 12'd7, 16'd0, 1'b0, 1'b0, k);
    cmd(c_rd, 2'd0, 12'd8, 16'd0, 1'b0, 1'b0, k);
    for (int i = 0; i < 4; i++) push(k + 2 + i, 16'(16'h0100 + i), 2'b11);
    nop(8);

    // Reset in the middle of a CL3 BL8 read
    cmd(c_mrs, 2'd0, 12'h033, 16'd0, 1'b0, 1'b0, k);
    cmd(c_rd, 2'd0, 12'd0, 16'd0, 1'b0, 1'b0, k);
    for (int i = 0; i < 3; i++) push(k + 3 + i, 16'((i + 2) % 8), 2'b11);
    nop(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_dq_oe", {30'd0, dq_oe}, 32'd0);
    chk("midreset_dq_out", {16'd0, dq_out}, 32'd0);
    chk("midreset_ref_cnt", {16'd0, ref_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd(c_rd, 2'd0, 12'd0, 16'd0, 1'b0, 1'b0, k);
    nop(4);
    chk("err_banks_closed", {24'd0, err_cnt}, 32'(c_chk * 1));
    cmd(c_act, 2'd0, 12'd7, 16'd0, 1'b0, 1'b0, k);
    cmd(c_rd, 2'd0, 12'd0, 16'd0, 1'b0, 1'b0, k);
    push(k + 2, 16'h0002, 2'b11);
    nop(10);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++; n_err++;
      $display("FAIL beat_pending: no beat at edge %0d, required d=%h oe=%b", e.cyc, e.d, e.oe);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable single-chip SDR SDRAM device emulator: the responder end of the x16 SDRAM command/data interface that mem_tester drives.
- Sits in place of the external chip for FPGA-internal loopback self-test and simulation of mem_tester without the board part.
- Decodes commands, tracks mode register and per-bank open rows, and serves reads/writes from an internal word store addressed by low bits of {bank,row,col}.

Parameters:
ROW_W, 12, row address width (12 = K4S281632, 13 = K4S561632)
COL_W, 9, column address width
MEM_AW, 12, internal store address width (2^MEM_AW x16 words); index = low MEM_AW bits of {ba,row,col}

Ports:
clk  in  1  sole clock, also the SDRAM command clock
rst_n  in  1  asynchronous active-low reset
cs_n, ras_n, cas_n, we_n  in  1 each  SDRAM command pins
ba  in  2  bank address {BA1,BA0}
addr  in  ROW_W  SDRAM address bus; A10 = auto-precharge / all-banks flag
ldqm, udqm  in  1 each  byte masks
dq_in  in  16  write data from controller
dq_out  out  16  read data to controller
dq_oe  out  2  per-byte output enable {upper,lower}
ref_cnt  out  16  REF commands accepted, wraps 0xFFFF->0
err_cnt  out  8  protocol violation count, saturates at 0xFF (see Optional Feature)

Behaviour:
- Reset (async): all banks closed, rows 0, mode BL=1 CL=2, no burst, dq_out=0, dq_oe=0, ref_cnt=0, err_cnt=0. Store contents not cleared. Reset mid-burst aborts the burst with dq_oe=0 immediately.
- Commands sampled on rising clk, as {cs_n,ras_n,cas_n,we_n}: 1xxx DESEL, 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE, 0001 REF, 0000 MRS, 0110 BST.
- MRS: A[2:0] 000/001/010/011 -> BL 1/2/4/8, other -> BL 1. A[6:4]=010 -> CL2, 011 -> CL3, other -> CL3. Other bits ignored. New mode applies to the next READ/WRITE.
- ACT: bank ba opened, row latched from addr. ACT to an already-open bank replaces the row (violation).
- PRE: A10=1 closes all banks, else bank ba. Also terminates any active burst on a closed bank.
- READ/WRITE to closed bank: ignored, no store access (violation). Otherwise col = addr[COL_W-1:0], burst starts.
- Burst addressing: sequential, wraps within the BL-aligned block: col_i = {col[COL_W-1:b], (col[b-1:0]+i) mod BL}, b=log2 BL.
- WRITE at edge k: beat i captured from dq_in at edge k+i. Byte written only if its DQM is 0 at that same edge.
- READ at edge k: beat i is valid on dq_out with dq_oe set so the controller samples it at edge k+CL+i. Outputs are registered. DQM sampled at edge j forces that byte's dq_oe to 0 for the beat sampled at edge j+2.
- A new READ/WRITE interrupts the current burst. A READ interrupting a READ: beats already in the CL pipeline still drive, then the new burst follows. A WRITE cancels all undriven read beats; dq_oe=0 from the WRITE edge.
- BST: ends the current burst after beats already issued.
- Auto-precharge (A10=1 on READ/WRITE): bank closes the cycle after the last beat is issued (sooner if interrupted).
- REF: ref_cnt+1. REF with any bank open is still counted (violation).
- DESEL/NOP: no state change, bursts continue.

Optional Feature:
- Macro SDRAM_RESP_CHECK_EN.
- Defined: err_cnt +1 (saturating) for each violation: ACT to open bank, READ/WRITE to closed bank, REF with a bank open, unsupported MRS BL or CL code.
- Not defined: err_cnt tied to 0, checker logic absent. Functional behaviour is identical either way.

Test Plan:
- MRS A=0x020 (CL2, BL1); ACT ba=1 row=5; WRITE col=3 dq_in=0xA55A; READ col=3 -> dq_oe=2'b11 and dq_out=0xA55A sampled exactly 2 edges after READ.
- MRS A=0x033 (CL3, BL8); ACT; WRITE col=6 with data 0..7 -> READ col=0 returns 2,3,4,5,6,7,0,1 (wrap inside 8-block), first beat 3 edges after READ.
- Write 0x1234, then WRITE 0xFFFF with udqm=1 -> readback 0x12FF. Read with ldqm=1 two edges before beat -> dq_oe=2'b10.
- READ to bank 2 never activated -> dq_oe stays 0, store unchanged, err_cnt=1 with macro, 0 without.
- WRITE+A10 to bank 0 BL4 -> bank 0 closed after beat 4; following READ ignored. Three REFs with all banks closed -> ref_cnt=3.
- Assert rst_n low mid-way through a BL8 CL3 read -> dq_oe=0 the same cycle, mode back to BL1/CL2, all banks closed.
